// File: rtl/mem_access_master_pkg.sv
// Shared state encodings, opcode constants and address-check helper for mem_access_master.
package mem_access_master_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam int CNT_W = 4;

  // Major opcodes the decoder uses to derive req_store.
  localparam logic [6:0] OPC_LW = 7'b0000011;
  localparam logic [6:0] OPC_SW = 7'b0100011;

  function automatic logic opcode_is_mem(input logic [6:0] opc);
    return (opc == OPC_LW) || (opc == OPC_SW);
  endfunction

  function automatic logic opcode_is_store(input logic [6:0] opc);
    return opc == OPC_SW;
  endfunction

  function automatic logic addr_illegal(input logic [1:0] low_bits, input logic high_nonzero);
    return (low_bits != 2'b00) || high_nonzero;
  endfunction

endpackage

// File: rtl/mem_access_master.sv
// Data-memory initiator: SETUP/ACCESS/RELEASE per request, response ACCESS_CYCLES+2 cycles after accept, req_ready low
// until RELEASE ends. MEM_ACCESS_ALIGN_CHECK_EN rejects misaligned or >=4 KiB addresses without touching the bus.
module mem_access_master
  import mem_access_master_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              store_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q, rdata_q;
  logic              ren_q, ren_d, wen_q, wen_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic              req_ready_q, req_ready_d;
  logic              accept, req_err, last_access;

  assign accept      = req_valid && req_ready_q;
  assign last_access = (state_q == ACCESS) && (cnt_q == '0);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign req_err = addr_illegal(req_addr[1:0], |req_addr[ADDR_W-1:12]);
`else
  assign req_err = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP: begin
        if (err_q) begin
          state_d = RELEASE;
        end else begin
          state_d = ACCESS;
          cnt_d   = CNT_LOAD;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) state_d = RELEASE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    ren_d        = (state_d == ACCESS) && !store_q;
    wen_d        = (state_d == ACCESS) && store_q;
    resp_valid_d = (state_d == RELEASE);
    resp_err_d   = (state_d == RELEASE) && err_q;
    req_ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      store_q      <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
      rdata_q      <= '0;
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      ren_q        <= ren_d;
      wen_q        <= wen_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      req_ready_q  <= req_ready_d;
      if (accept) begin
        store_q <= req_store;
        err_q   <= req_err;
        addr_q  <= req_addr;
        if (req_store) din_q <= req_wdata;
      end
      if (last_access && !store_q) rdata_q <= mem_dout;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = rdata_q;
  assign mem_addr   = addr_q;
  assign mem_din    = din_q;
  assign mem_ren    = ren_q;
  assign mem_wen    = wen_q;

endmodule

// File: tb/tb_mem_access_master.sv
// Scoreboard bench for mem_access_master at ACCESS_CYCLES 2, 1 and 15, each driving a behavioural data memory.
`timescale 1ns/1ps
module tb_mem_access_master;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int NCFG   = 3;
  localparam int N_RAND = 40;

  typedef struct {
    logic          store;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    int            acc;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int AC = (g == 0) ? 2 : ((g == 1) ? 1 : 15);

    logic          reset;
    logic          req_valid, req_ready, req_store;
    logic [AW-1:0] req_addr, mem_addr;
    logic [DW-1:0] req_wdata, resp_rdata, mem_din, mem_dout;
    logic          resp_valid, resp_err, mem_ren, mem_wen;

    logic [DW-1:0] mem     [0:1023];
    logic [DW-1:0] ref_mem [0:1023];
    logic [DW-1:0] last_rdata;
    exp_t          exp_q[$];
    int            cyc = 0;
    logic          fin = 1'b0;

    int            prev_acc;
    logic          prev_err, held;

    exp_t          m_e;
    logic          m_en, en_prev, ren_seen, wen_seen;
    int            en_cnt, first_en;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_din;

    mem_access_master #(.ACCESS_CYCLES(AC), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
      .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Combinational-read, level-write data memory, word indexed.
    assign mem_dout = mem[mem_addr[11:2]];
    always @(posedge clock) if (mem_wen) mem[mem_addr[11:2]] <= mem_din;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic issue(input logic st, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int acc, output logic err);
      exp_t e;
      int   w;
      req_valid = 1'b1; req_store = st; req_addr = a; req_wdata = d;
      w = 0;
      while (!req_ready && w < 200) begin @(negedge clock); w++; end
      checks++;
      if (!req_ready) begin
        errors++;
        $display("FAIL c%0d accept_timeout: req_ready stayed 0 for %0d cycles, required 1", g, w);
        acc = -1; err = 1'b0;
        req_valid = 1'b0;
      end else begin
        acc = cyc + 1;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        err = (a[1:0] != 2'b00) || (a[AW-1:12] != '0);
`else
        err = 1'b0;
`endif
        if (!err) begin
          if (st) ref_mem[a[11:2]] = d;
          else    last_rdata = ref_mem[a[11:2]];
        end
        e.store = st; e.addr = a; e.wdata = d; e.rdata = last_rdata; e.err = err; e.acc = acc;
        exp_q.push_back(e);
        @(negedge clock);
      end
    endtask

    task automatic txn(input logic st, input logic [AW-1:0] a, input logic [DW-1:0] d, input int gap);
      int   acc;
      logic err;
      issue(st, a, d, acc, err);
      if (held && acc >= 0 && prev_acc >= 0)
        check($sformatf("c%0d accept_gap", g), 64'(acc - prev_acc), 64'(prev_err ? 3 : AC + 3));
      prev_acc = acc; prev_err = err; held = (gap == 0);
      if (gap > 0) begin
        req_valid = 1'b0;
        repeat (gap) @(negedge clock);
      end
    endtask

    task automatic check_reset_outputs(input string tag);
      check($sformatf("c%0d %s req_ready", g, tag), 64'(req_ready), 64'(1));
      check($sformatf("c%0d %s resp_valid", g, tag), 64'(resp_valid), 64'(0));
      check($sformatf("c%0d %s resp_err", g, tag), 64'(resp_err), 64'(0));
      check($sformatf("c%0d %s resp_rdata", g, tag), 64'(resp_rdata), 64'(0));
      check($sformatf("c%0d %s ren_wen", g, tag), 64'({mem_ren, mem_wen}), 64'(0));
      check($sformatf("c%0d %s mem_addr", g, tag), 64'(mem_addr), 64'(0));
      check($sformatf("c%0d %s mem_din", g, tag), 64'(mem_din), 64'(0));
    endtask

    // Monitor: bus protocol every cycle, scoreboard pop on each response.
    always @(negedge clock) begin
      if (reset) begin
        en_cnt = 0; first_en = 0; ren_seen = 1'b0; wen_seen = 1'b0; en_prev = 1'b0;
      end else begin
        check($sformatf("c%0d ren_wen_exclusive", g), 64'(mem_ren && mem_wen), 64'(0));
        m_en = mem_ren | mem_wen;
        if (m_en || en_prev) begin
          check($sformatf("c%0d addr_stable", g), 64'(mem_addr), 64'(prev_addr));
          check($sformatf("c%0d din_stable", g), 64'(mem_din), 64'(prev_din));
        end
        if (m_en) begin
          if (en_cnt == 0 && exp_q.size() > 0) first_en = cyc - exp_q[0].acc + 1;
          en_cnt++;
          ren_seen |= mem_ren;
          wen_seen |= mem_wen;
        end
        en_prev = m_en; prev_addr = mem_addr; prev_din = mem_din;
        if (resp_valid) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL c%0d unexpected_resp: resp_valid=1 with no request outstanding", g);
          end else begin
            m_e = exp_q.pop_front();
            check($sformatf("c%0d latency", g), 64'(cyc - m_e.acc + 1), 64'(m_e.err ? 2 : AC + 2));
            check($sformatf("c%0d resp_err", g), 64'(resp_err), 64'(m_e.err));
            check($sformatf("c%0d resp_rdata", g), 64'(resp_rdata), 64'(m_e.rdata));
            check($sformatf("c%0d mem_addr_held", g), 64'(mem_addr), 64'(m_e.addr));
            if (m_e.store) check($sformatf("c%0d mem_din_held", g), 64'(mem_din), 64'(m_e.wdata));
            check($sformatf("c%0d enable_width", g), 64'(en_cnt), 64'(m_e.err ? 0 : AC));
            check($sformatf("c%0d ren_seen", g), 64'(ren_seen), 64'(!m_e.err && !m_e.store));
            check($sformatf("c%0d wen_seen", g), 64'(wen_seen), 64'(!m_e.err && m_e.store));
            if (!m_e.err) check($sformatf("c%0d first_enable_cycle", g), 64'(first_en), 64'(2));
          end
          en_cnt = 0; first_en = 0; ren_seen = 1'b0; wen_seen = 1'b0;
        end
      end
    end

    initial begin
      logic [AW-1:0] a;
      logic [DW-1:0] oldw, neww, got;
      int            r, w;
      for (int i = 0; i < 1024; i++) begin
        oldw = $urandom;
        mem[i] = oldw; ref_mem[i] = oldw;
      end
      last_rdata = '0; prev_acc = -1; prev_err = 1'b0; held = 1'b0;
      req_valid = 1'b0; req_store = 1'b0; req_addr = '0; req_wdata = '0;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      check_reset_outputs("reset");
      #1 reset = 1'b0;
      @(negedge clock);

      txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2);
      txn(1'b0, 32'h0000_0010, 32'h0, 1);
      txn(1'b0, 32'h0000_0012, 32'h0, 1);
      txn(1'b1, 32'h0000_0020, 32'h1234_5678, 0);
      txn(1'b0, 32'h0000_0020, 32'h0, 0);
      txn(1'b0, 32'h0001_0010, 32'h0, 0);
      txn(1'b0, 32'h0000_0010, 32'h0, 1);

      for (int n = 0; n < N_RAND; n++) begin
        r = $urandom_range(0, 9);
        a = 32'h100 + (32'($urandom_range(0, 15)) << 2);
        if (r == 7) a = a | 32'($urandom_range(1, 3));
        if (r >= 8) a = a | (32'($urandom_range(1, 255)) << 16);
        txn(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2));
      end
      req_valid = 1'b0;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clock);

      // Reset in the middle of a store's ACCESS phase.
      a = 32'h0000_0040;
      oldw = ref_mem[a[11:2]];
      neww = $urandom;
      issue(1'b1, a, neww, r, prev_err);
      req_valid = 1'b0;
      w = 0;
      while (!mem_wen && w < 20) begin @(negedge clock); w++; end
      check($sformatf("c%0d wen_before_reset", g), 64'(mem_wen), 64'(1));
      #2 reset = 1'b1;
      #1;
      check_reset_outputs("mid_access_reset");
      exp_q.delete();
      @(negedge clock);
      #1 reset = 1'b0;
      got = mem[a[11:2]];
      checks++;
      if ($isunknown(got) || (got !== oldw && got !== neww)) begin
        errors++;
        $display("FAIL c%0d reset_mem_word: got 0x%0h, required 0x%0h or 0x%0h", g, got, oldw, neww);
      end
      ref_mem[a[11:2]] = got;
      last_rdata = '0; prev_acc = -1; held = 1'b0;
      @(negedge clock);

      txn(1'b0, a, 32'h0, 0);
      txn(1'b1, 32'h0000_0044, 32'hCAFE_F00D, 0);
      txn(1'b0, 32'h0000_0044, 32'h0, 1);
      req_valid = 1'b0;

      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL c%0d drain: %0d responses outstanding, required 0", g, exp_q.size());
      end
      fin = 1'b1;
    end
  end

  initial begin
    int i;
    i = 0;
    while (i < 60000 && !(cfg[0].fin && cfg[1].fin && cfg[2].fin)) begin
      @(negedge clock);
      i++;
    end
    checks++;
    if (!(cfg[0].fin && cfg[1].fin && cfg[2].fin)) begin
      errors++;
      $display("FAIL watchdog: stimulus unfinished after %0d cycles, required completion", i);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
